// File: rtl/t_ff_toggle_seq.sv
// Pulse sequencer driving a T flip-flop, with expected-output tracking.
// Optional dout/exp checker enabled by T_FF_TOGGLE_SEQ_CHECK_EN.
module t_ff_toggle_seq #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic             din_t,
    input  logic             dout_q,
    output logic             busy,
    output logic             done,
    output logic             exp_q,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOGGLE,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] REM_ONE  = 1;
    localparam logic [CNT_W-1:0] REM_ZERO = 0;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_ZERO = 0;

    state_e           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gcnt_q;
    logic             exp_r_q;

    assign cmd_ready = (state_q == S_IDLE);
    assign din_t     = (state_q == S_TOGGLE);
    assign busy      = (state_q == S_TOGGLE) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign exp_q     = exp_r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= REM_ZERO;
            gap_q   <= GAP_ZERO;
            gcnt_q  <= GAP_ZERO;
            exp_r_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Resync to the T-FF so a fresh command starts aligned.
                    exp_r_q <= dout_q;
                    if (cmd_valid) begin
                        rem_q   <= cmd_cnt;
                        gap_q   <= cmd_gap;
                        state_q <= (cmd_cnt == REM_ZERO) ? S_DONE : S_TOGGLE;
                    end
                end
                S_TOGGLE: begin
                    exp_r_q <= ~exp_r_q;
                    rem_q   <= rem_q - REM_ONE;
                    if (rem_q == REM_ONE || abort) begin
                        state_q <= S_DONE;
                    end else if (gap_q == GAP_ZERO) begin
                        state_q <= S_TOGGLE;
                    end else begin
                        state_q <= S_GAP;
                        gcnt_q  <= gap_q;
                    end
                end
                S_GAP: begin
                    gcnt_q <= gcnt_q - GAP_ONE;
                    if (abort) begin
                        state_q <= S_DONE;
                    end else if (gcnt_q == GAP_ONE) begin
                        state_q <= S_TOGGLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef T_FF_TOGGLE_SEQ_CHECK_EN
    logic err_q;
    logic mis;

    assign mis = (state_q != S_IDLE) && (dout_q != exp_r_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && cmd_valid) begin
            err_q <= 1'b0;
        end else if (mis) begin
            err_q <= 1'b1;
        end
    end

    // Live mismatch is flagged immediately; err_q keeps it sticky.
    assign err = err_q | mis;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_t_ff_toggle_seq.sv
// Directed bench for t_ff_toggle_seq with a behavioural T-FF model.
// Vector table plus hand-written reset, hold and checker sequences.
module tb_t_ff_toggle_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_cnt;
    logic [3:0] cmd_gap;
    logic       abort;
    logic       din_t;
    logic       dout_q;
    logic       busy;
    logic       done;
    logic       exp_q;
    logic       err;

    logic       tff_q;
    logic       stuck;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) tff_q <= 1'b0;
        else if (din_t) tff_q <= ~tff_q;
    end

    assign dout_q = stuck ? 1'b0 : tff_q;

    t_ff_toggle_seq #(.CNT_W(8), .GAP_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_cnt(cmd_cnt),
        .cmd_gap(cmd_gap),
        .abort(abort),
        .din_t(din_t),
        .dout_q(dout_q),
        .busy(busy),
        .done(done),
        .exp_q(exp_q),
        .err(err)
    );

    typedef struct {
        int cnt;
        int gap;
        int abort_cyc;
        int pulses;
        int first;
        int last;
        int done_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        int np, fst, lst, dc, nd, rb, tb, bb, eb, st;
        vec_t v;
        v = vecs[i];
        np = 0; fst = 0; lst = 0; dc = 0; nd = 0;
        rb = 0; tb = 0; bb = 0; eb = 0;
        st = int'(tff_q);
        cmd_valid = 1'b1;
        cmd_cnt = 8'(v.cnt);
        cmd_gap = 4'(v.gap);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= v.done_cyc + 1; c++) begin
            if (din_t) begin
                np++;
                if (fst == 0) fst = c;
                lst = c;
            end
            if (done) begin
                nd++;
                dc = c;
            end
            if (cmd_ready != (c == v.done_cyc + 1)) rb++;
            if (busy != (c < v.done_cyc)) bb++;
            if (exp_q != dout_q) tb++;
            if (err) eb++;
            abort = (c == v.abort_cyc);
            if (c <= v.done_cyc) step();
        end
        abort = 1'b0;
        check($sformatf("v%0d pulses", i), np, v.pulses);
        check($sformatf("v%0d first", i), fst, v.first);
        check($sformatf("v%0d last", i), lst, v.last);
        check($sformatf("v%0d done_cyc", i), dc, v.done_cyc);
        check($sformatf("v%0d done_cnt", i), nd, 1);
        check($sformatf("v%0d ready_bad", i), rb, 0);
        check($sformatf("v%0d busy_bad", i), bb, 0);
        check($sformatf("v%0d track_bad", i), tb, 0);
        check($sformatf("v%0d err_bad", i), eb, 0);
        check($sformatf("v%0d exp_end", i), int'(exp_q),
              st ^ (v.pulses & 1));
    endtask

    initial begin
        logic [15:0] din_m, done_m, rdy_m;
        int np, nd;

        vecs[0] = '{3, 0, 0, 3, 1, 3, 4};
        vecs[1] = '{2, 2, 0, 2, 1, 4, 5};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 1};
        vecs[3] = '{5, 1, 4, 2, 1, 3, 5};
        vecs[4] = '{5, 1, 5, 3, 1, 5, 6};
        vecs[5] = '{5, 1, 0, 5, 1, 9, 10};
        vecs[6] = '{1, 15, 0, 1, 1, 1, 2};
        vecs[7] = '{4, 3, 0, 4, 1, 13, 14};
        vecs[8] = '{255, 0, 0, 255, 1, 255, 256};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_cnt = 8'd0;
        cmd_gap = 4'd0;
        abort = 1'b0;
        stuck = 1'b0;
        step();
        step();
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst din_t", int'(din_t), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst exp_q", int'(exp_q), 0);
        check("rst err", int'(err), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_vec(i);
        check("tffq after table", int'(dout_q), int'(exp_q));

        // cmd_valid held through a busy command must not be queued
        din_m = '0; done_m = '0; rdy_m = '0;
        cmd_valid = 1'b1;
        cmd_cnt = 8'd2;
        cmd_gap = 4'd2;
        step();
        cmd_cnt = 8'd1;
        cmd_gap = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            din_m[c] = din_t;
            done_m[c] = done;
            rdy_m[c] = cmd_ready;
            if (c == 7) cmd_valid = 1'b0;
            step();
        end
        check("hold din mask", int'(din_m), 16'h0092);
        check("hold done mask", int'(done_m), 16'h0120);
        check("hold ready mask", int'(rdy_m), 16'h0040);
        check("hold ready end", int'(cmd_ready), 1);

        // reset during GAP of a cnt=4 command
        cmd_valid = 1'b1;
        cmd_cnt = 8'd4;
        cmd_gap = 4'd3;
        step();
        cmd_valid = 1'b0;
        check("mid din c1", int'(din_t), 1);
        step();
        check("mid busy c2", int'(busy), 1);
        check("mid din c2", int'(din_t), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid rst ready", int'(cmd_ready), 1);
        check("mid rst din", int'(din_t), 0);
        check("mid rst done", int'(done), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst exp", int'(exp_q), 0);
        np = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (din_t) np++;
            if (done) nd++;
            step();
        end
        check("post rst pulses", np, 0);
        check("post rst done", nd, 0);

`ifdef T_FF_TOGGLE_SEQ_CHECK_EN
        stuck = 1'b1;
        step();
        cmd_valid = 1'b1;
        cmd_cnt = 8'd1;
        cmd_gap = 4'd0;
        step();
        cmd_valid = 1'b0;
        check("chk err pulse", int'(err), 0);
        step();
        check("chk err done", int'(err), 1);
        step();
        check("chk err idle1", int'(err), 1);
        stuck = 1'b0;
        step();
        check("chk err idle2", int'(err), 1);
        cmd_valid = 1'b1;
        cmd_cnt = 8'd0;
        step();
        cmd_valid = 1'b0;
        check("chk err clear", int'(err), 0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/t_ff_toggle_seq.md
# t_ff_toggle_seq

Command-driven sequencer for a single T flip-flop toggle datapath. Accepts a toggle command (pulse count, inter-pulse gap) over a valid/ready handshake and drives the T-FF `din_t` input with exactly that many one-cycle pulses at the requested spacing. Tracks the expected T-FF output, reports completion, and supports abort. Sits between a host/control FSM and a `t_ff` instance whose `dout_q` is fed back for tracking and checking.

## Interface
- `CNT_W`, 8: width of the pulse-count field.
- `GAP_W`, 4: width of the gap field.

- `clk`  in  1  rising-edge clock, shared with the T-FF.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_cnt`  in  CNT_W  number of toggle pulses; 0 is legal.
- `cmd_gap`  in  GAP_W  idle cycles between consecutive pulses.
- `abort`  in  1  stop the current command early.
- `din_t`  out  1  toggle enable to the T-FF.
- `dout_q`  in  1  T-FF output, fed back.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `exp_q`  out  1  expected T-FF output.
- `err`  out  1  sticky mismatch flag. Only active with the checker macro defined.

## Operation
- States: IDLE, TOGGLE, GAP, DONE. Single state register.
- Reset values: state=IDLE, `cmd_ready`=1, `din_t`=0, `busy`=0, `done`=0, `exp_q`=0, `err`=0. All counters are 0.
- Outputs are decoded from the state only:
  - `cmd_ready` = (IDLE).
  - `din_t` = (TOGGLE).
  - `busy` = (TOGGLE or GAP).
  - `done` = (DONE).
- IDLE:
  - `exp_q` <= `dout_q` every cycle, to resynchronize to the T-FF.
  - On `cmd_valid && cmd_ready`: latch `rem` <= `cmd_cnt` and `gap` <= `cmd_gap`. Go to DONE if `cmd_cnt`==0, else go to TOGGLE.
- TOGGLE: each TOGGLE cycle is exactly one issued pulse.
  - `exp_q` <= ~`exp_q`; `rem` <= `rem`-1.
  - Next state: DONE if `rem`==1 or `abort`. Otherwise TOGGLE if `gap`==0 (back-to-back pulses). Otherwise GAP, with `gcnt` <= `gap`.
- GAP:
  - `gcnt` <= `gcnt`-1.
  - `abort` → DONE, and no further pulse is issued.
  - `gcnt`==1 → TOGGLE.
- DONE: always goes to IDLE. `abort` is ignored in IDLE and DONE.
- `abort` in TOGGLE: that cycle's pulse is still counted and toggles `exp_q`.
- `cmd_valid` outside IDLE: ignored, never queued. The host must hold `cmd_valid` until `cmd_ready`.
- Arithmetic: `rem` and `gcnt` never wrap. Maximum values are all-ones: 2^CNT_W-1 pulses and 2^GAP_W-1 gap cycles.
- Reset asserted mid-command: the next cycle is IDLE with `din_t`=0. No pulse and no `done` pulse is emitted.

## Timing
- Command accepted at edge k (the edge where `cmd_valid && cmd_ready` is sampled); the first `din_t` high is in cycle k+1.
- Pulse spacing is `gap`+1 cycles, start to start.
- Last pulse is in cycle k+cnt+(cnt-1)·gap.
- `done` is high in the cycle after the last pulse. `cmd_ready` is high in the following cycle.
- `cnt`=0: `done` in cycle k+1, `cmd_ready` in k+2, no pulse.
- Minimum command-to-command turnaround: accepts are spaced cnt+(cnt-1)·gap+2 cycles apart.
- `exp_q` changes on the same edge the T-FF samples `din_t`=1. `exp_q` equals `dout_q` in every cycle when the T-FF operates correctly.

## Configuration
- `T_FF_TOGGLE_SEQ_CHECK_EN` defined:
  - `err` is set when state is TOGGLE, GAP or DONE and `dout_q` != `exp_q`.
  - `err` is sticky. It is cleared only by `rst` or by the next command accept.
- `T_FF_TOGGLE_SEQ_CHECK_EN` undefined: `err` is tied to 0 and no compare logic is built. The port list is unchanged.

## Test plan
- Reset with `dout_q`=0, then command cnt=3, gap=0 → `din_t` high in cycles k+1..k+3, `done` in k+4. `exp_q`=1 and `dout_q`=1 at the end.
- Command cnt=2, gap=2 → pulses in k+1 and k+4, `done` in k+5, `exp_q` returns to its start value. A `cmd_valid` held during `busy` is not accepted until `cmd_ready`.
- Command cnt=0 → no `din_t` pulse, `done` in k+1, `cmd_ready` back in k+2.
- cnt=5, gap=1, `abort` in the 2nd GAP cycle → exactly 2 pulses, then `done`. `abort` in the cycle of the 3rd TOGGLE → exactly 3 pulses.
- `rst` asserted during GAP of a cnt=4 command → next cycle IDLE, `din_t`=0, `done`=0, `cmd_ready`=1.
- With `T_FF_TOGGLE_SEQ_CHECK_EN`: force `dout_q` stuck at 0 during cnt=1 → `err`=1 from the cycle after the pulse, holds through IDLE, clears on the next accept.
